// File: rtl/tile_turn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tile_turn_scheduler
// Purpose  : Walks the backtracking search across the grid's tiles. Holds the
//            cursor (index of the tile in control), grants a one-hot turn to
//            that tile, skips pre-filled tiles, advances on a forward pass,
//            retreats on a backward pass and reports done/success.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clock       system clock, all state updates on posedge
//   i_reset       synchronous active-high reset
//   i_start       level; starts a solve when idle or done
//   i_givens      bit i high = tile i pre-filled, never granted a turn
//   i_pass_fwd    granted tile committed a value; move to next tile
//   i_pass_back   granted tile exhausted candidates; move to previous tile
//   o_my_turn     one-hot turn grant, zero outside the waiting state
//   o_from_back   turn arrived by retreat (resume) rather than advance
//   o_cursor      current tile index
//   o_busy        search in progress
//   o_done        search finished
//   o_success     valid with o_done; high = solved
//   o_backtracks  saturating count of accepted backward passes
// ============================================================================
module tile_turn_scheduler #(
    parameter int NUM_TILES = 81,
    parameter int IDX_W     = 7,
    parameter int CNT_W     = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [NUM_TILES-1:0] i_givens,
    input  logic                 i_pass_fwd,
    input  logic                 i_pass_back,
    output logic [NUM_TILES-1:0] o_my_turn,
    output logic                 o_from_back,
    output logic [IDX_W-1:0]     o_cursor,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_success,
    output logic [CNT_W-1:0]     o_backtracks
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEEK_FWD  = 3'd1,
        S_SEEK_BACK = 3'd2,
        S_WAIT      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    // The givens vector is widened to the full cursor range so that indexing
    // with the cursor is always in bounds, including cursor == NUM_TILES.
    localparam int               c_EXT_W   = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] c_END_IDX = IDX_W'(NUM_TILES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_cursor;
    logic [IDX_W-1:0]   w_cursor_nxt;
    logic               r_from_back;
    logic               w_from_back_nxt;
    logic               r_success;
    logic               w_success_nxt;
    logic [CNT_W-1:0]   r_backtracks;
    logic [CNT_W-1:0]   w_backtracks_nxt;

    logic [c_EXT_W-1:0] w_givens_ext;
    logic               w_cur_given;
    logic               w_at_end;
    logic               w_at_zero;
    logic [CNT_W-1:0]   w_bt_inc;

    assign w_givens_ext = {{(c_EXT_W - NUM_TILES){1'b0}}, i_givens};
    assign w_cur_given  = w_givens_ext[r_cursor];
    assign w_at_end     = (r_cursor == c_END_IDX);
    assign w_at_zero    = (r_cursor == '0);
    assign w_bt_inc     = (&r_backtracks) ? r_backtracks
                                          : r_backtracks + CNT_W'(1);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_cursor     <= '0;
            r_from_back  <= 1'b0;
            r_success    <= 1'b0;
            r_backtracks <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cursor     <= w_cursor_nxt;
            r_from_back  <= w_from_back_nxt;
            r_success    <= w_success_nxt;
            r_backtracks <= w_backtracks_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cursor_nxt     = r_cursor;
        w_from_back_nxt  = r_from_back;
        w_success_nxt    = r_success;
        w_backtracks_nxt = r_backtracks;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_nxt      = S_SEEK_FWD;
                    w_cursor_nxt     = '0;
                    w_from_back_nxt  = 1'b0;
                    w_success_nxt    = 1'b0;
                    w_backtracks_nxt = '0;
                end
            end

            S_SEEK_FWD: begin
                // End check first: past the last tile means every tile holds
                // a value.
                if (w_at_end) begin
                    w_state_nxt   = S_DONE;
                    w_success_nxt = 1'b1;
                end else if (w_cur_given) begin
                    w_cursor_nxt = r_cursor + IDX_W'(1);
                end else begin
                    w_state_nxt     = S_WAIT;
                    w_from_back_nxt = 1'b0;
                end
            end

            S_SEEK_BACK: begin
                if (w_cur_given) begin
                    // Retreating past a given tile 0 leaves nothing to retry.
                    if (w_at_zero) begin
                        w_state_nxt   = S_DONE;
                        w_success_nxt = 1'b0;
                    end else begin
                        w_cursor_nxt = r_cursor - IDX_W'(1);
                    end
                end else begin
                    w_state_nxt     = S_WAIT;
                    w_from_back_nxt = 1'b1;
                end
            end

            S_WAIT: begin
                // A backward pass takes priority over a simultaneous forward one.
                if (i_pass_back) begin
                    w_backtracks_nxt = w_bt_inc;
                    if (w_at_zero) begin
                        w_state_nxt   = S_DONE;
                        w_success_nxt = 1'b0;
                    end else begin
                        w_state_nxt  = S_SEEK_BACK;
                        w_cursor_nxt = r_cursor - IDX_W'(1);
                    end
                end else if (i_pass_fwd) begin
                    w_state_nxt  = S_SEEK_FWD;
                    w_cursor_nxt = r_cursor + IDX_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_turn
            assign o_my_turn[gi] = (r_state == S_WAIT) && (r_cursor == IDX_W'(gi));
        end
    endgenerate

    assign o_from_back  = r_from_back && (r_state == S_WAIT);
    assign o_cursor     = r_cursor;
    assign o_busy       = (r_state == S_SEEK_FWD) || (r_state == S_SEEK_BACK)
                       || (r_state == S_WAIT);
    assign o_done       = (r_state == S_DONE);
    assign o_success    = r_success;
    assign o_backtracks = r_backtracks;

endmodule
`default_nettype wire

// File: tb/tb_tile_turn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_turn_scheduler
// Purpose  : Self-checking bench for tile_turn_scheduler (4 tiles, 2-bit
//            backtrack counter). A queue-based model plans the cycle-by-cycle
//            walk whenever a solve starts or a pass is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_turn_scheduler;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] givens;
    logic         pass_fwd;
    logic         pass_back;
    logic [N-1:0] my_turn;
    logic         from_back;
    logic [2:0]   cursor;
    logic         busy;
    logic         done;
    logic         success;
    logic [1:0]   backtracks;

    int n_checks = 0;
    int n_fail   = 0;
    bit en       = 1'b0;

    tile_turn_scheduler #(
        .NUM_TILES (N),
        .IDX_W     (3),
        .CNT_W     (2)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_givens     (givens),
        .i_pass_fwd   (pass_fwd),
        .i_pass_back  (pass_back),
        .o_my_turn    (my_turn),
        .o_from_back  (from_back),
        .o_cursor     (cursor),
        .o_busy       (busy),
        .o_done       (done),
        .o_success    (success),
        .o_backtracks (backtracks)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------ model
    typedef struct packed {
        logic [N-1:0] turn;
        logic         fb;
        logic [2:0]   cur;
        logic         busy;
        logic         done;
        logic         succ;
        logic [1:0]   bt;
    } snap_t;

    snap_t m_cur = '0;
    snap_t m_q[$];

    function automatic snap_t mk(int c, bit bsy, bit wt, bit fb, bit dn,
                                 bit sc, logic [1:0] bt);
        snap_t s;
        logic [N-1:0] one;
        one    = 1;
        s.turn = wt ? (one << c) : '0;
        s.fb   = fb;
        s.cur  = 3'(c);
        s.busy = bsy;
        s.done = dn;
        s.succ = sc;
        s.bt   = bt;
        return s;
    endfunction

    // Walk forward from tile c: one cycle per visited cursor, ending in a
    // grant or in a successful finish past the last tile.
    task automatic plan_fwd(int c0, logic [1:0] bt);
        for (int c = c0; c <= N; c++) begin
            m_q.push_back(mk(c, 1, 0, 0, 0, 0, bt));
            if (c == N) begin
                m_q.push_back(mk(c, 0, 0, 0, 1, 1, bt));
                return;
            end
            if (!givens[c]) begin
                m_q.push_back(mk(c, 1, 1, 0, 0, 0, bt));
                return;
            end
        end
    endtask

    task automatic plan_back(int c0, logic [1:0] bt);
        for (int c = c0; c >= 0; c--) begin
            m_q.push_back(mk(c, 1, 0, 0, 0, 0, bt));
            if (!givens[c]) begin
                m_q.push_back(mk(c, 1, 1, 1, 0, 0, bt));
                return;
            end
            if (c == 0) begin
                m_q.push_back(mk(0, 0, 0, 0, 1, 0, bt));
                return;
            end
        end
    endtask

    always @(posedge clk) begin
        logic [1:0] nbt;
        if (rst) begin
            m_q.delete();
            m_cur = '0;
        end else if (m_cur.turn != '0 && (pass_back || pass_fwd)) begin
            if (pass_back) begin
                nbt = (m_cur.bt == 2'd3) ? 2'd3 : m_cur.bt + 2'd1;
                if (m_cur.cur == 3'd0)
                    m_q.push_back(mk(0, 0, 0, 0, 1, 0, nbt));
                else
                    plan_back(int'(m_cur.cur) - 1, nbt);
            end else begin
                plan_fwd(int'(m_cur.cur) + 1, m_cur.bt);
            end
            m_cur = m_q.pop_front();
        end else if (!m_cur.busy && start) begin
            m_q.delete();
            plan_fwd(0, 2'd0);
            m_cur = m_q.pop_front();
        end else if (m_q.size() > 0) begin
            m_cur = m_q.pop_front();
        end
    end

    // ---------------------------------------------------------------- compare
    always @(negedge clk) begin
        snap_t act;
        if (en) begin
            act.turn = my_turn;
            act.fb   = from_back;
            act.cur  = cursor;
            act.busy = busy;
            act.done = done;
            act.succ = success;
            act.bt   = backtracks;
            n_checks++;
            if (act !== m_cur) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t actual turn=%b fb=%b cur=%0d busy=%b done=%b succ=%b bt=%0d required turn=%b fb=%b cur=%0d busy=%b done=%b succ=%b bt=%0d",
                         $time, act.turn, act.fb, act.cur, act.busy, act.done, act.succ, act.bt,
                         m_cur.turn, m_cur.fb, m_cur.cur, m_cur.busy, m_cur.done, m_cur.succ, m_cur.bt);
            end
        end
    end

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fwd();
        pass_fwd = 1'b1;
        tick();
        pass_fwd = 1'b0;
    endtask

    task automatic pulse_back();
        pass_back = 1'b1;
        tick();
        pass_back = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        rst = 1'b1; start = 1'b0; givens = '0; pass_fwd = 1'b0; pass_back = 1'b0;
        tick(); tick();
        en  = 1'b1;
        rst = 1'b0;
        chk("reset_turn", 16'(my_turn), 16'h0);
        chk("reset_status", 16'({busy, done, success, from_back}), 16'h0);
        chk("reset_cursor_bt", 16'({cursor, backtracks}), 16'h0);

        // pass_fwd in IDLE is ignored
        pulse_fwd();
        chk("idle_fwd_ignored", 16'({busy, cursor}), 16'h0);

        // All free: walk forward to success
        givens = 4'b0000;
        do_start();
        chk("seek_busy", 16'(busy), 16'h1);
        tick();
        chk("first_grant", 16'({my_turn, from_back}), 16'b0001_0);
        for (int t = 0; t < 3; t++) begin
            pulse_fwd();
            chk("turn_dropped", 16'(my_turn), 16'h0);
            tick();
            chk("fwd_grant", 16'(my_turn), 16'(1 << (t + 1)));
        end
        pulse_fwd();
        tick();
        chk("solved", 16'({done, success, backtracks, cursor}), 16'({1'b1, 1'b1, 2'd0, 3'd4}));

        // Givens 0110: skip forward, then retreat across them
        givens = 4'b0110;
        do_start();
        tick();
        chk("g0110_grant0", 16'(my_turn), 16'b0001);
        pulse_fwd();
        chk("skip_c1", 16'(cursor), 16'd1);
        tick();
        chk("skip_c2", 16'(cursor), 16'd2);
        tick();
        chk("skip_c3", 16'({my_turn, cursor}), 16'({4'b0000, 3'd3}));
        tick();
        chk("g0110_grant3", 16'(my_turn), 16'b1000);
        pulse_back();
        chk("back_c2", 16'({busy, cursor}), 16'({1'b1, 3'd2}));
        tick();
        chk("back_c1", 16'(cursor), 16'd1);
        tick();
        chk("back_c0", 16'({my_turn, cursor}), 16'd0);
        tick();
        chk("regrant0", 16'({my_turn, from_back, backtracks}), 16'({4'b0001, 1'b1, 2'd1}));
        do_start();
        chk("start_ignored_busy", 16'({my_turn, backtracks}), 16'({4'b0001, 2'd1}));

        // Backward pass on tile 0: no solution
        pulse_back();
        chk("nosol", 16'({done, success, backtracks}), 16'({1'b1, 1'b0, 2'd2}));
        givens = 4'b0000;
        do_start();
        chk("restart_clears", 16'({done, success, backtracks}), 16'h0);
        tick();
        chk("restart_grant", 16'(my_turn), 16'b0001);
        pulse_back();
        chk("nosol2", 16'({done, success, backtracks}), 16'({1'b1, 1'b0, 2'd1}));

        // All given: no grants, finish after walking every tile
        givens = 4'b1111;
        do_start();
        for (int k = 0; k < 4; k++) begin
            chk("allgiven_noturn", 16'({my_turn, done}), 16'h0);
            tick();
        end
        chk("allgiven_c4", 16'({my_turn, done, cursor}), 16'({4'b0000, 1'b0, 3'd4}));
        tick();
        chk("allgiven_done", 16'({done, success, cursor}), 16'({1'b1, 1'b1, 3'd4}));

        // Simultaneous passes on tile 2, then saturate the counter
        givens = 4'b0000;
        do_start();
        tick();
        pulse_fwd(); tick();
        pulse_fwd(); tick();
        chk("wait_t2", 16'(my_turn), 16'b0100);
        pass_fwd = 1'b1; pass_back = 1'b1;
        tick();
        pass_fwd = 1'b0; pass_back = 1'b0;
        chk("both_back", 16'({busy, cursor, backtracks}), 16'({1'b1, 3'd1, 2'd1}));
        tick();
        chk("both_grant1", 16'({my_turn, from_back}), 16'b0010_1);
        pulse_fwd(); tick();
        pulse_fwd(); tick();
        chk("wait_t3", 16'({my_turn, from_back}), 16'b1000_0);
        pulse_back(); tick();
        chk("bt2", 16'({my_turn, backtracks}), 16'({4'b0100, 2'd2}));
        pulse_back(); tick();
        chk("bt3", 16'({my_turn, backtracks}), 16'({4'b0010, 2'd3}));
        pulse_back(); tick();
        chk("bt_sat", 16'({my_turn, backtracks}), 16'({4'b0001, 2'd3}));
        pulse_back();
        chk("bt_sat_done", 16'({done, success, backtracks}), 16'({1'b1, 1'b0, 2'd3}));

        // Reset while waiting on tile 3
        do_start();
        tick();
        for (int k = 0; k < 3; k++) begin
            pulse_fwd(); tick();
        end
        chk("wait_t3b", 16'(my_turn), 16'b1000);
        rst = 1'b1; pass_fwd = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; pass_fwd = 1'b0; start = 1'b0;
        chk("midreset", 16'({my_turn, from_back, cursor, busy, done, success, backtracks}), 16'h0);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (!m_cur.busy && $urandom_range(0, 3) == 0)
                givens = N'($urandom);
            start     = ($urandom_range(0, 5) == 0);
            pass_fwd  = ($urandom_range(0, 2) == 0);
            pass_back = ($urandom_range(0, 6) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; pass_fwd = 1'b0; pass_back = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
